// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART driver: circular buffer plus a launch/handshake FSM that
// pops one byte, pulses uart_start, then tracks the driver's busy/ready handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BUSY_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         clr_overflow,
  input  logic                         uart_ready,
  input  logic                         uart_busy,
  output logic                         uart_start,
  output logic [7:0]                   uart_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(BUSY_WAIT + 1);

  localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
  localparam logic [WW-1:0] WaitLast = WW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [WW-1:0]   r_wait_cnt;
  logic [WW-1:0]   w_wait_cnt_next;

  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_full;
  logic            r_empty;
  logic            r_overflow;
  logic [7:0]      r_uart_data;

  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // A pop frees a slot on the same edge, so a push into a full FIFO is still taken then.
  assign w_pop  = (r_state == StIdle) && !r_empty && uart_ready;
  assign w_push = wr_en && (!r_full || w_pop);
  assign w_drop = wr_en && r_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_next = StLaunch;
        end
      end
      StLaunch: begin
        w_state_next    = StWaitBusy;
        w_wait_cnt_next = '0;
      end
      StWaitBusy: begin
        // A short frame may finish before busy is ever seen; give up after BUSY_WAIT cycles.
        if (uart_busy || (r_wait_cnt == WaitLast)) begin
          w_state_next = StWaitDone;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WW'(1);
        end
      end
      StWaitDone: begin
        if (!uart_busy && uart_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_uart_data <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_uart_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CntFull);
      r_empty <= (w_count_next == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign uart_start = (r_state == StLaunch);
  assign uart_data  = r_uart_data;
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a small UART driver model.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int BUSY_WAIT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       tb_ready = 1'b0;
  logic       uart_ready;
  logic       uart_busy = 1'b0;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int cyc = 0;
  int drv_mode = 0;
  int dly = 0;
  int left = 0;
  logic [7:0] rx_q[$];
  int st_cyc[$];

  assign uart_ready = tb_ready && !uart_busy;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .uart_ready   (uart_ready),
    .uart_busy    (uart_busy),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Driver model (mode 0: busy 2 cycles after start, for 10 cycles; mode 1: never busy)
  // and launch monitor, both on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      dly = 0;
      left = 0;
      uart_busy = 1'b0;
    end else begin
      if (left > 0) begin
        left--;
        if (left == 0) uart_busy = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          uart_busy = 1'b1;
          left = 10;
        end
      end
      if (uart_start) begin
        if (drv_mode == 0) dly = 2;
        start_cnt++;
        rx_q.push_back(uart_data);
        st_cyc.push_back(cyc);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", uart_start); end
    checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", uart_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
  endtask

  task automatic test_single_byte();
    int b;
    b = rx_q.size();
    drv_mode = 0;
    tb_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL lat_empty got=%b exp=0", empty); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", count); end
    checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL lat_early_start got=%b exp=0", uart_start); end
    @(posedge clk); #1;
    checks++; if (uart_start !== 1'b1) begin failures++; $display("FAIL lat_start got=%b exp=1", uart_start); end
    checks++; if (uart_data !== 8'hA5) begin failures++; $display("FAIL lat_data got=%h exp=a5", uart_data); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL lat_pop_empty got=%b exp=1", empty); end
    @(posedge clk); #1;
    checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL start_one_cycle got=%b exp=0", uart_start); end
    repeat (25) @(posedge clk);
    #1;
    checks++; if (rx_q.size() !== b + 1) begin failures++; $display("FAIL single_starts got=%0d exp=%0d", rx_q.size(), b + 1); end
    checks++; if (rx_q.size() > b && rx_q[b] !== 8'hA5) begin failures++; $display("FAIL single_rx got=%h exp=a5", rx_q[b]); end
  endtask

  task automatic test_fill_overflow();
    int s0;
    s0 = start_cnt;
    tb_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
    wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL drop_overflow got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL drop_count got=%0d exp=16", count); end
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL not_ready_start got=%0d exp=%0d", start_cnt, s0); end
  endtask

  task automatic test_overflow_clear();
    wr_en = 1'b1; wr_data = 8'hDD; clr_overflow = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL set_clr_count got=%0d exp=16", count); end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int b;
    b = rx_q.size();
    drv_mode = 0;
    tb_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h10;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL pp_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL pp_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL pp_head got=%h exp=00", uart_data); end
    for (int i = 0; i < 800 && rx_q.size() < b + 17; i++) @(posedge clk);
    #1;
    checks++; if (rx_q.size() < b + 17) begin failures++; $display("FAIL drain_timeout got=%0d exp=%0d", rx_q.size() - b, 17); end
    for (int i = 0; i < 17; i++) begin
      if (rx_q.size() > b + i) begin
        checks++;
        if (rx_q[b + i] !== 8'(i)) begin
          failures++; $display("FAIL order_%0d got=%h exp=%h", i, rx_q[b + i], 8'(i));
        end
      end
    end
    repeat (25) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    checks++; if (rx_q.size() !== b + 17) begin failures++; $display("FAIL drain_extra got=%0d exp=17", rx_q.size() - b); end
  endtask

  task automatic test_busy_timeout();
    int b;
    b = rx_q.size();
    drv_mode = 1;
    tb_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h3C;
    @(posedge clk); #1;
    wr_data = 8'hC3;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (uart_data !== 8'h3C) begin failures++; $display("FAIL data_stable got=%h exp=3c", uart_data); end
    for (int i = 0; i < 100 && rx_q.size() < b + 2; i++) @(posedge clk);
    #1;
    checks++; if (rx_q.size() < b + 2) begin failures++; $display("FAIL timeout_launch got=%0d exp=2", rx_q.size() - b); end
    if (rx_q.size() >= b + 2) begin
      checks++; if (st_cyc[b + 1] - st_cyc[b] !== 11) begin failures++; $display("FAIL timeout_gap got=%0d exp=11", st_cyc[b + 1] - st_cyc[b]); end
      checks++; if (rx_q[b] !== 8'h3C || rx_q[b + 1] !== 8'hC3) begin failures++; $display("FAIL timeout_data got=%h,%h exp=3c,c3", rx_q[b], rx_q[b + 1]); end
    end
    repeat (15) @(posedge clk);
    #1;
    drv_mode = 0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL timeout_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid_transfer();
    int s0;
    drv_mode = 0;
    tb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h11 * 8'(i + 1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 20 && uart_busy !== 1'b1; i++) @(posedge clk);
    checks++; if (uart_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_timeout got=%b exp=1", uart_busy); end
    repeat (2) @(posedge clk);
    #2;
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL mid_count got=%0d exp=2", count); end
    s0 = start_cnt;
    rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL arst_flags got=%b/%b exp=1/0", empty, full); end
    checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL arst_data got=%h exp=00", uart_data); end
    checks++; if (uart_start !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_start_ovf got=%b/%b exp=0/0", uart_start, overflow); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL rst_no_start got=%0d exp=%0d", start_cnt, s0); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_discard got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    int b;
    logic [7:0] exp [3];
    exp[0] = 8'h5A; exp[1] = 8'h6B; exp[2] = 8'h7C;
    b = rx_q.size();
    drv_mode = 0;
    tb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = exp[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 200 && rx_q.size() < b + 3; i++) @(posedge clk);
    #1;
    checks++; if (rx_q.size() < b + 3) begin failures++; $display("FAIL b2b_timeout got=%0d exp=3", rx_q.size() - b); end
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > b + i) begin
        checks++;
        if (rx_q[b + i] !== exp[i]) begin
          failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, rx_q[b + i], exp[i]);
        end
      end
    end
    repeat (25) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_overflow_clear();
    test_full_push_pop();
    test_busy_timeout();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have parameter BUSY_WAIT, default 8, meaning the maximum number of cycles to wait for uart_busy after a launch.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: push request from the producer.
REQ-006 The block SHALL have port wr_data, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL have port clr_overflow, input, 1 bit: clears the sticky overflow flag.
REQ-008 The block SHALL have port uart_ready, input, 1 bit: driver can accept a byte.
REQ-009 The block SHALL have port uart_busy, input, 1 bit: driver is transmitting.
REQ-010 The block SHALL have port uart_start, output, 1 bit: single-cycle launch pulse to the driver.
REQ-011 The block SHALL have port uart_data, output, 8 bits: byte presented to the driver.
REQ-012 The block SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 The block SHALL have port empty, output, 1 bit: count == 0.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: occupancy.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.

Function
REQ-016 Storage SHALL be a circular buffer with read and write pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0 without a gap.
REQ-017 A push SHALL be accepted when wr_en=1 and either full=0 or a pop occurs in the same cycle.
REQ-018 A push with wr_en=1, full=1 and no pop SHALL be dropped, leave FIFO contents and count unchanged, and set overflow on the next edge.
REQ-019 Overflow SHALL stay set until clr_overflow=1; if a set condition and clr_overflow occur in the same cycle, set SHALL win.
REQ-020 count, full and empty SHALL be registered and updated on the edge following push/pop: push only +1, pop only -1, both unchanged.
REQ-021 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-022 IDLE -> LAUNCH SHALL occur when empty=0 and uart_ready=1; the head byte SHALL be popped on that edge and loaded into uart_data.
REQ-023 In LAUNCH, uart_start SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT_BUSY with the wait counter cleared.
REQ-024 In WAIT_BUSY, uart_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-025 In WAIT_BUSY, after BUSY_WAIT cycles without uart_busy, the FSM SHALL move to WAIT_DONE (driver may have finished already).
REQ-026 In WAIT_DONE, uart_busy=0 and uart_ready=1 SHALL move the FSM to IDLE.
REQ-027 uart_data SHALL stay stable from the pop until the next pop.
REQ-028 uart_start SHALL never assert outside LAUNCH.
REQ-029 Latency: a byte pushed into an empty FIFO at edge N, with the FSM in IDLE and uart_ready=1, SHALL make empty=0 after edge N, pop at edge N+1, and give uart_start=1 in cycle N+1..N+2 (one cycle).
REQ-030 Bytes SHALL be delivered in strict push order with no duplication or loss, except for dropped pushes.
REQ-031 uart_ready=0 in IDLE SHALL hold the FSM with no pop.

Reset
REQ-032 When rst asserts, the block SHALL immediately clear pointers and count, and set empty=1, full=0, overflow=0, uart_start=0, uart_data=8'h00 and FSM=IDLE.
REQ-033 rst asserted mid-transfer (any state) SHALL abort the transfer and discard all queued bytes; no uart_start SHALL be emitted until new data is pushed after rst deasserts.
REQ-034 FIFO memory contents SHALL NOT require reset.

Verification
REQ-035 Reset, then push 8'hA5 with uart_ready=1 and a driver model raising busy 2 cycles after start for 10 cycles -> one uart_start pulse with uart_data=8'hA5; FSM returns to IDLE; empty=1.
REQ-036 Push 16 bytes 0x00..0x0F with uart_ready=0 -> full=1, count=16; a 17th push sets overflow=1 and count stays 16; then release ready -> 0x00..0x0F delivered in order.
REQ-037 With full=1, push and pop in the same cycle -> push accepted, count stays 16, overflow stays 0.
REQ-038 Driver model never asserts busy -> FSM leaves WAIT_BUSY after exactly BUSY_WAIT=8 cycles, and the next byte launches once ready=1.
REQ-039 Push 3 bytes, assert rst during WAIT_DONE of the first byte -> outputs at reset values, count=0, no further uart_start.
REQ-040 Set overflow and assert clr_overflow in the same cycle as another dropped push -> overflow stays 1; clr_overflow alone on a later cycle -> overflow=0.
